// File: rtl/ram_cell_ctrl_pkg.sv
// Shared types and sizing helpers for the data-cell controller.
package ram_cell_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_INC   = 3'd0,
        OP_DEC   = 3'd1,
        OP_RIGHT = 3'd2,
        OP_LEFT  = 3'd3,
        OP_READ  = 3'd4,
        OP_CLEAR = 3'd5,
        OP_NOP   = 3'd6,
        OP_NOP7  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StAck
    } state_t;

    function automatic int unsigned addr_width(input int unsigned num, input int unsigned width);
        return num * width;
    endfunction

endpackage

// File: rtl/ram_addr_ptr.sv
// Data pointer register: up/down counter that wraps at both ends, synchronous reset.
module ram_addr_ptr #(
    parameter int unsigned Width = 18
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [Width-1:0] ptr_o
);

    logic [Width-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + Width'(1);
        end else if (dec_i) begin
            ptr_d = ptr_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_cell_ctrl.sv
// Data-cell controller: owns the data pointer and sequences RAM read-modify-write for cell ops.
// Optional cell cache (skips RAM reads when the cell is already known) under RAM_CELL_CACHE_EN.
module ram_cell_ctrl
    import ram_cell_ctrl_pkg::*;
#(
    parameter int unsigned DEKATRON_NUM   = 6,
    parameter int unsigned DEKATRON_WIDTH = 3,
    parameter int unsigned DATA_WIDTH     = 4,
    localparam int unsigned AW = addr_width(DEKATRON_NUM, DEKATRON_WIDTH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req,
    input  logic [2:0]            Op,
    output logic                  Busy,
    output logic                  Ack,
    output logic [AW-1:0]         AP,
    output logic [DATA_WIDTH-1:0] Cell,
    output logic                  CellZero,
    output logic [AW-1:0]         RamAddress,
    output logic [DATA_WIDTH-1:0] RamIn,
    input  logic [DATA_WIDTH-1:0] RamOut,
    output logic                  RamWE_n,
    output logic                  RamCS
);

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic [DATA_WIDTH-1:0] cell_q, cell_d;
    logic [DATA_WIDTH-1:0] ram_in;
    logic                  ap_inc, ap_dec;
    logic                  cache_hit;
    op_t                   op_in;

`ifdef RAM_CELL_CACHE_EN
    logic cache_valid_q, cache_valid_d;
    assign cache_hit = cache_valid_q;
`else
    assign cache_hit = 1'b0;
`endif

    assign op_in = op_t'(Op);

    ram_addr_ptr #(
        .Width (AW)
    ) u_addr_ptr (
        .clk_i (Clk),
        .rst_i (Rst),
        .inc_i (ap_inc),
        .dec_i (ap_dec),
        .ptr_o (AP)
    );

    // Write data is only meaningful in WR; held at zero otherwise so the bus idles quietly.
    always_comb begin
        ram_in = '0;
        if (state_q == StWr) begin
            case (op_q)
                OP_INC:  ram_in = cell_q + DATA_WIDTH'(1);
                OP_DEC:  ram_in = cell_q - DATA_WIDTH'(1);
                default: ram_in = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cell_d  = cell_q;
        ap_inc  = 1'b0;
        ap_dec  = 1'b0;
`ifdef RAM_CELL_CACHE_EN
        cache_valid_d = cache_valid_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (Req) begin
                    op_d = op_in;
                    case (op_in)
                        OP_INC, OP_DEC: state_d = cache_hit ? StWr : StRd;
                        OP_READ:        state_d = cache_hit ? StAck : StRd;
                        OP_CLEAR:       state_d = StWr;
                        OP_RIGHT: begin
                            ap_inc  = 1'b1;
                            state_d = StAck;
`ifdef RAM_CELL_CACHE_EN
                            cache_valid_d = 1'b0;
`endif
                        end
                        OP_LEFT: begin
                            ap_dec  = 1'b1;
                            state_d = StAck;
`ifdef RAM_CELL_CACHE_EN
                            cache_valid_d = 1'b0;
`endif
                        end
                        default:        state_d = StAck;
                    endcase
                end
            end
            StRd: state_d = StCap;
            StCap: begin
                cell_d  = RamOut;
                state_d = (op_q == OP_READ) ? StAck : StWr;
`ifdef RAM_CELL_CACHE_EN
                cache_valid_d = 1'b1;
`endif
            end
            StWr: begin
                cell_d  = ram_in;
                state_d = StAck;
`ifdef RAM_CELL_CACHE_EN
                cache_valid_d = 1'b1;
`endif
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            op_q    <= OP_NOP;
            cell_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cell_q  <= cell_d;
        end
    end

`ifdef RAM_CELL_CACHE_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cache_valid_q <= 1'b0;
        end else begin
            cache_valid_q <= cache_valid_d;
        end
    end
`endif

    assign Busy       = (state_q != StIdle);
    assign Ack        = (state_q == StAck);
    assign RamCS      = (state_q == StRd) || (state_q == StCap) || (state_q == StWr);
    assign RamWE_n    = (state_q != StWr);
    assign RamIn      = ram_in;
    assign RamAddress = AP;
    assign Cell       = cell_q;
    assign CellZero   = (cell_q == '0);

endmodule

// File: tb/tb_ram_cell_ctrl.sv
// Directed bench for ram_cell_ctrl with a synchronous-read RAM model and backdoor preload.
module tb_ram_cell_ctrl;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Req;
    logic [2:0]    Op;
    logic          Busy, Ack, CellZero, RamWE_n, RamCS;
    logic [AW-1:0] AP, RamAddress;
    logic [DW-1:0] Cell, RamIn, RamOut;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    int checks = 0;
    int errors = 0;

    ram_cell_ctrl dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Req        (Req),
        .Op         (Op),
        .Busy       (Busy),
        .Ack        (Ack),
        .AP         (AP),
        .Cell       (Cell),
        .CellZero   (CellZero),
        .RamAddress (RamAddress),
        .RamIn      (RamIn),
        .RamOut     (RamOut),
        .RamWE_n    (RamWE_n),
        .RamCS      (RamCS)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (RamCS) begin
            if (!RamWE_n) mem[RamAddress] <= RamIn;
            else          RamOut <= mem[RamAddress];
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    // Issue one op, return cycles from accept edge to Ack and whether RAM was touched.
    task automatic run_op(input logic [2:0] op, output int lat, output bit saw_cs,
                          output bit saw_rd);
        Req = 1'b1;
        Op  = op;
        tick();
        Req    = 1'b0;
        lat    = 1;
        saw_cs = 1'b0;
        saw_rd = 1'b0;
        while (!Ack && lat < 20) begin
            if (RamCS) saw_cs = 1'b1;
            if (RamCS && RamWE_n) saw_rd = 1'b1;
            tick();
            lat++;
        end
        chk("ack_seen", {31'd0, Ack}, 32'd1);
        tick();
    endtask

    int lat;
    bit saw_cs, saw_rd;
    int acks, busys;

    initial begin
        Rst = 1'b1;
        Req = 1'b0;
        Op  = 3'd6;
        tick();
        tick();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_ack", {31'd0, Ack}, 32'd0);
        chk("rst_ap", {14'd0, AP}, 32'd0);
        chk("rst_cell", {28'd0, Cell}, 32'd0);
        chk("rst_cs", {31'd0, RamCS}, 32'd0);
        chk("rst_we_n", {31'd0, RamWE_n}, 32'd1);
        chk("rst_ramin", {28'd0, RamIn}, 32'd0);
        Rst = 1'b0;

        // INC, stepped state by state
        preload(18'd0, 4'd5);
        Req = 1'b1;
        Op  = 3'd0;
        tick();
        Req = 1'b0;
        chk("inc_rd_cs", {30'd0, RamCS, RamWE_n}, 32'd3);
        chk("inc_rd_busy", {31'd0, Busy}, 32'd1);
        tick();
        chk("inc_cap_cs", {30'd0, RamCS, RamWE_n}, 32'd3);
        tick();
        chk("inc_wr_cs", {30'd0, RamCS, RamWE_n}, 32'd2);
        chk("inc_wr_data", {28'd0, RamIn}, 32'd6);
        tick();
        chk("inc_ack", {31'd0, Ack}, 32'd1);
        chk("inc_mem", {28'd0, mem[0]}, 32'd6);
        chk("inc_cell", {28'd0, Cell}, 32'd6);
        chk("inc_ack_cs", {31'd0, RamCS}, 32'd0);
        tick();
        chk("inc_ack_pulse", {31'd0, Ack}, 32'd0);
        chk("inc_idle", {31'd0, Busy}, 32'd0);

        // DEC wrap from 0, then CLEAR
        preload(18'd0, 4'd0);
        run_op(3'd1, lat, saw_cs, saw_rd);
        chk("dec_lat", lat, 32'd4);
        chk("dec_mem", {28'd0, mem[0]}, 32'd15);
        chk("dec_cell", {28'd0, Cell}, 32'd15);
        chk("dec_zero", {31'd0, CellZero}, 32'd0);
        run_op(3'd5, lat, saw_cs, saw_rd);
        chk("clr_lat", lat, 32'd2);
        chk("clr_rd", {31'd0, saw_rd}, 32'd0);
        chk("clr_mem", {28'd0, mem[0]}, 32'd0);
        chk("clr_zero", {31'd0, CellZero}, 32'd1);

        // INC wrap from max
        preload(18'd0, 4'd15);
        run_op(3'd0, lat, saw_cs, saw_rd);
        chk("incw_mem", {28'd0, mem[0]}, 32'd0);
        chk("incw_zero", {31'd0, CellZero}, 32'd1);

        // READ
        preload(18'd0, 4'd9);
        run_op(3'd4, lat, saw_cs, saw_rd);
        chk("rd_lat", lat, 32'd3);
        chk("rd_cell", {28'd0, Cell}, 32'd9);
        chk("rd_mem", {28'd0, mem[0]}, 32'd9);

        // Pointer wrap both ways, no RAM access
        run_op(3'd3, lat, saw_cs, saw_rd);
        chk("left_lat", lat, 32'd1);
        chk("left_ap", {14'd0, AP}, 32'h3ffff);
        chk("left_addr", {14'd0, RamAddress}, 32'h3ffff);
        chk("left_cs", {31'd0, saw_cs}, 32'd0);
        run_op(3'd2, lat, saw_cs, saw_rd);
        chk("right_lat", lat, 32'd1);
        chk("right_ap", {14'd0, AP}, 32'd0);
        chk("right_cs", {31'd0, saw_cs}, 32'd0);
        run_op(3'd7, lat, saw_cs, saw_rd);
        chk("nop_lat", lat, 32'd1);
        chk("nop_cs", {31'd0, saw_cs}, 32'd0);

        // Req held high: one op per IDLE visit
        preload(18'd0, 4'd2);
        Req   = 1'b1;
        Op    = 3'd0;
        acks  = 0;
        busys = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (Ack) acks++;
            if (Busy) busys++;
        end
        Req = 1'b0;
        chk("held_acks", acks, 32'd2);
        chk("held_busy", busys, 32'd8);
        chk("held_mem", {28'd0, mem[0]}, 32'd4);
        tick();
        chk("held_idle", {31'd0, Busy}, 32'd0);

        // Reset while in CAP of an INC at AP=1
        run_op(3'd2, lat, saw_cs, saw_rd);
        preload(18'd1, 4'd7);
        Req = 1'b1;
        Op  = 3'd0;
        tick();
        Req = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("rstop_busy", {31'd0, Busy}, 32'd0);
        chk("rstop_ap", {14'd0, AP}, 32'd0);
        chk("rstop_cell", {28'd0, Cell}, 32'd0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (Ack) acks++;
            tick();
        end
        chk("rstop_noack", acks, 32'd0);
        chk("rstop_mem", {28'd0, mem[1]}, 32'd7);

`ifdef RAM_CELL_CACHE_EN
        preload(18'd0, 4'd3);
        run_op(3'd4, lat, saw_cs, saw_rd);
        chk("cache_rd_cell", {28'd0, Cell}, 32'd3);
        run_op(3'd0, lat, saw_cs, saw_rd);
        chk("cache_inc_lat", lat, 32'd2);
        chk("cache_inc_rd", {31'd0, saw_rd}, 32'd0);
        chk("cache_inc_mem", {28'd0, mem[0]}, 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
